// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared types and constants for the systolic-array input path.
//   DATA_W_DEF      : default activation element width
//   DEPTH_DEF       : default feeder FIFO depth (vectors)
//   act_vec_t       : one host activation vector {a0, a1, last} at default width
//   feeder_state_t  : input_skew_feeder FSM states
//   vec_bits()      : packed width of an activation vector for a given width
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a0;
        logic [DATA_W_DEF-1:0] a1;
        logic                  last;
    } act_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    // Two elements plus the end-of-matrix flag.
    function automatic int vec_bits(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data and a flush input.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : discard all contents (pointers and count to zero)
//   push, wr_data: write request and data; ignored while full or flushing
//   pop          : read request; ignored while empty or flushing
//   rd_data      : entry at the read pointer (valid whenever !empty)
//   full, empty  : status derived from the registered occupancy count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_skew_feeder.sv
// -----------------------------------------------------------------------------
// input_skew_feeder
// Buffers 2-element activation vectors and, once a whole matrix is resident,
// streams them into the 2x2 systolic array with a one-cycle diagonal skew on
// row 1. Each N-row matrix produces N+1 consecutive valid cycles, the last
// being a drain cycle flagged by done.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : host handshake. A vector transfers on a rising edge
//                       where both are high; in_ready is !full from the
//                       registered FIFO count and never depends on in_valid.
//                       The host may hold in_valid and data until accepted.
//   in_a0, in_a1      : elements for array rows 0 and 1
//   in_last           : vector is the final row of a matrix
//   valid             : a_in1/a_in2 live this cycle (no ready: array always
//                       consumes)
//   a_in1, a_in2      : to PE(0,0) and PE(1,0); a_in2 lags by one row
//   busy              : FSM not in IDLE
//   done              : one-cycle pulse on the drain output cycle
//   err               : sticky; FIFO filled with no end-of-matrix marker
//   state_dbg         : current FSM state (feeder_state_t encoding)
// -----------------------------------------------------------------------------
module input_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a0,
    input  logic [DATA_W-1:0] in_a1,
    input  logic              in_last,
    output logic              valid,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int VEC_W = vec_bits(DATA_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a0;
        logic [DATA_W-1:0] a1;
        logic              last;
    } vec_t;

    feeder_state_t state;
    feeder_state_t state_next;

    logic [VEC_W-1:0]  wr_bits;
    logic [VEC_W-1:0]  rd_bits;
    vec_t              rd_vec;
    logic              fifo_full;
    logic              fifo_empty;

    logic              push;
    logic              pop_en;
    logic              err_cond;
    logic [CNT_W-1:0]  last_cnt;
    logic [DATA_W-1:0] skew;

    // Next values for the registered array-side outputs.
    logic              valid_d;
    logic [DATA_W-1:0] a1_d;
    logic [DATA_W-1:0] a2_d;
    logic [DATA_W-1:0] skew_d;
    logic              done_d;

    assign wr_bits  = {in_a0, in_a1, in_last};
    assign rd_vec   = vec_t'(rd_bits);
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // A full FIFO without a complete matrix can never drain: flush it.
    assign err_cond = fifo_full && (last_cnt == '0);

    sync_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (err_cond),
        .push    (push),
        .wr_data (wr_bits),
        .pop     (pop_en),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (err_cond) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (last_cnt != '0) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    if (!fifo_empty && rd_vec.last) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // IDLE (and error) drive zeros, which also clears skew so the first
    // a_in2 of every matrix is 0.
    always_comb begin
        pop_en  = 1'b0;
        valid_d = 1'b0;
        a1_d    = '0;
        a2_d    = '0;
        skew_d  = '0;
        done_d  = 1'b0;
        if (!err_cond) begin
            case (state)
                STREAM: begin
                    // A complete matrix is resident, so the FIFO cannot run
                    // dry before the last row; the empty guard is defensive.
                    if (!fifo_empty) begin
                        pop_en  = 1'b1;
                        valid_d = 1'b1;
                        a1_d    = rd_vec.a0;
                        a2_d    = skew;
                        skew_d  = rd_vec.a1;
                    end
                end
                DRAIN: begin
                    valid_d = 1'b1;
                    a2_d    = skew;
                    done_d  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            a_in1 <= '0;
            a_in2 <= '0;
            skew  <= '0;
            done  <= 1'b0;
        end else begin
            valid <= valid_d;
            a_in1 <= a1_d;
            a_in2 <= a2_d;
            skew  <= skew_d;
            done  <= done_d;
        end
    end

    // Count of end-of-matrix markers held in the FIFO; a push of a last row
    // and a pop of a last row in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (reset || err_cond) begin
            last_cnt <= '0;
        end else begin
            case ({push && in_last, pop_en && rd_vec.last})
                2'b10:   last_cnt <= last_cnt + CNT_W'(1);
                2'b01:   last_cnt <= last_cnt - CNT_W'(1);
                default: last_cnt <= last_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_cond) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_input_skew_feeder
// Directed bench for input_skew_feeder (DATA_W=16, DEPTH=8). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_input_skew_feeder;

    localparam int          W       = 34;  // {valid, a_in1, a_in2, done}
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_STREAM = 2'd1;
    localparam logic [1:0]  S_DRAIN  = 2'd2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a0;
    logic [15:0] in_a1;
    logic        in_last;
    logic        valid;
    logic [15:0] a_in1;
    logic [15:0] a_in2;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    input_skew_feeder #(
        .DATA_W (16),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a0     (in_a0),
        .in_a1     (in_a1),
        .in_last   (in_last),
        .valid     (valid),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic v, input logic [15:0] a1,
                                        input logic [15:0] a2, input logic d);
        return {v, a1, a2, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Full idle picture: outputs zero, not busy, ready, state IDLE.
    task automatic check_idle(input string tag);
        chk(tag, {valid, a_in1, a_in2, done, busy, in_ready, state_dbg},
                 {1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, S_IDLE});
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_row(input logic [15:0] a0, input logic [15:0] a1, input logic last);
        int guard;
        guard    = 0;
        in_a0    = a0;
        in_a1    = a1;
        in_last  = last;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("push_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    // Waits (bounded) for the first valid, then checks exp_q cycle by cycle.
    task automatic run_monitor(input string tag);
        int guard;
        logic [W-1:0] e;
        guard = 0;
        while (valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_start"}, valid, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, {valid, a_in1, a_in2, done}, e);
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a0    = '0;
        in_a1    = '0;
        in_last  = 1'b0;
        repeat (3) tick();
        check_idle("reset_outputs");
        chk("reset_err", err, 1'b0);
        reset = 1'b0;
        tick();

        // Two-row matrix (1,2),(3,4 last).
        exp_q = {};
        exp_q.push_back(ev(1'b1, 16'd1, 16'd0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd3, 16'd2, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd0, 16'd4, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        fork
            begin
                push_row(16'd1, 16'd2, 1'b0);
                push_row(16'd3, 16'd4, 1'b1);
            end
            run_monitor("two_row");
        join
        check_idle("two_row_end");

        // Single row (5,6 last) with exact latency: push at edge t.
        push_row(16'd5, 16'd6, 1'b1);
        chk("single_after_t", {valid, busy}, 2'b00);
        tick();
        chk("single_t1", {valid, busy, state_dbg}, {1'b0, 1'b1, S_STREAM});
        tick();
        chk("single_t2", {valid, a_in1, a_in2, done, state_dbg},
                         {1'b1, 16'd5, 16'd0, 1'b0, S_DRAIN});
        tick();
        chk("single_t3", {valid, a_in1, a_in2, done, busy},
                         {1'b1, 16'd0, 16'd6, 1'b1, 1'b0});
        tick();
        check_idle("single_end");

        // X=(1,1),(2,2 last); Y=(7,8 last) pushed on the edge that pops X's
        // last row, so the marker count sees a simultaneous inc and dec.
        exp_q = {};
        exp_q.push_back(ev(1'b1, 16'd1, 16'd0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd2, 16'd1, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd0, 16'd2, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd7, 16'd0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd0, 16'd8, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        fork
            begin
                push_row(16'd1, 16'd1, 1'b0);
                push_row(16'd2, 16'd2, 1'b1);
                tick();
                tick();
                push_row(16'd7, 16'd8, 1'b1);
            end
            run_monitor("overlap");
        join
        check_idle("overlap_end");

        // Eight rows without last: full, then error and flush.
        for (int i = 0; i < 8; i++) begin
            push_row(16'h20 + 16'(i), 16'h30 + 16'(i), 1'b0);
            chk("ovf_no_valid", valid, 1'b0);
        end
        chk("ovf_full", {in_ready, err, valid}, 3'b000);
        tick();
        chk("ovf_err", {in_ready, err, valid, busy}, 4'b1100);
        repeat (3) begin
            tick();
            chk("ovf_sticky", {err, valid, in_ready}, 3'b101);
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("ovf_reset_err", err, 1'b0);
        check_idle("ovf_reset_idle");

        exp_q = {};
        exp_q.push_back(ev(1'b1, 16'd9, 16'd0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'd0, 16'd10, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        fork
            push_row(16'd9, 16'd10, 1'b1);
            run_monitor("post_err");
        join
        check_idle("post_err_end");

        // Reset in the second STREAM cycle of a four-row matrix.
        push_row(16'h11, 16'h12, 1'b0);
        push_row(16'h21, 16'h22, 1'b0);
        push_row(16'h31, 16'h32, 1'b0);
        push_row(16'h41, 16'h42, 1'b1);
        tick();
        chk("abort_stream1", {valid, busy, state_dbg}, {1'b0, 1'b1, S_STREAM});
        tick();
        chk("abort_stream2", {valid, a_in1, a_in2, state_dbg},
                             {1'b1, 16'h11, 16'h0, S_STREAM});
        reset = 1'b1;
        tick();
        check_idle("abort_reset");
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_no_leftover", {valid, busy}, 2'b00);
        end
        exp_q = {};
        exp_q.push_back(ev(1'b1, 16'h55, 16'h0, 1'b0));
        exp_q.push_back(ev(1'b1, 16'h0, 16'h66, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        fork
            push_row(16'h55, 16'h66, 1'b1);
            run_monitor("abort_next");
        join

        // Two back-to-back 8-row matrices with in_valid held: fills to DEPTH
        // and wraps the pointers.
        exp_q = {};
        for (int k = 0; k < 8; k++)
            exp_q.push_back(ev(1'b1, 16'h100 + 16'(k), (k == 0) ? 16'h0 : 16'h200 + 16'(k - 1), 1'b0));
        exp_q.push_back(ev(1'b1, 16'h0, 16'h207, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        for (int k = 0; k < 8; k++)
            exp_q.push_back(ev(1'b1, 16'h300 + 16'(k), (k == 0) ? 16'h0 : 16'h400 + 16'(k - 1), 1'b0));
        exp_q.push_back(ev(1'b1, 16'h0, 16'h407, 1'b1));
        exp_q.push_back(ev(1'b0, 16'd0, 16'd0, 1'b0));
        fork
            begin
                for (int k = 0; k < 8; k++)
                    push_row(16'h100 + 16'(k), 16'h200 + 16'(k), k == 7);
                chk("fill_ready_low", in_ready, 1'b0);
                for (int k = 0; k < 8; k++)
                    push_row(16'h300 + 16'(k), 16'h400 + 16'(k), k == 7);
            end
            run_monitor("fill_wrap");
        join
        check_idle("fill_wrap_end");
        chk("final_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_skew_feeder.md
# input_skew_feeder

Upstream feeder for the 2x2 systolic array (`mmu`). It buffers 2-element activation vectors from the host side in a small FIFO. Once a complete matrix is resident, it streams the vectors into `a_in1`/`a_in2` with the one-cycle diagonal skew the array needs, asserting `valid` for every cycle the array must consume. It sits between the instruction/host input path and the `mmu`/`accumulator` pair, which share its `valid`.

## Interface
Parameters:
- `DATA_W`, 16: activation element width.
- `DEPTH`, 8: FIFO depth in vectors, i.e. maximum rows per matrix; power of two, ≥2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: host vector present.
- `in_ready`  out  1: FIFO can accept; equals `!full`.
- `in_a0`  in  DATA_W: element for array row 0.
- `in_a1`  in  DATA_W: element for array row 1.
- `in_last`  in  1: this vector is the final row of a matrix.
- `valid`  out  1: `a_in1`/`a_in2` are live this cycle; drives `mmu.valid` and accumulator `valid`.
- `a_in1`  out  DATA_W: to PE(0,0).
- `a_in2`  out  DATA_W: to PE(1,0).
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse on the final (drain) output cycle of a matrix.
- `err`  out  1: sticky protocol error.

## Operation
- Push: `in_valid && in_ready` writes {a0, a1, last} to the FIFO.
- `last_cnt` counts last-flagged entries in the FIFO. It increments on a push with `in_last` and decrements on a pop of a last entry. A simultaneous inc and dec leaves it unchanged.
- FSM states:
  - **IDLE**: if `last_cnt != 0`, go to STREAM. Otherwise hold.
  - **STREAM**: pop one vector per cycle; bubbles are never inserted. Register outputs:
    - `a_in1 <= v.a0`
    - `a_in2 <= skew`
    - `skew <= v.a1`
    - `valid <= 1`
    
    On popping the entry with `last=1`, go to DRAIN.
  - **DRAIN**: register `a_in1 <= 0`, `a_in2 <= skew`, `valid <= 1`, `done <= 1`, `skew <= 0`; go to IDLE.
- `skew` is zero on entry to STREAM, so the first `a_in2` of every matrix is 0.
- Outputs in IDLE: `valid=0`, `a_in1=a_in2=0`.
- Pushes are accepted in every state. The next matrix may be loaded while the current one streams.
- Error: if FIFO is full and `last_cnt==0` (matrix longer than DEPTH, deadlock):
  - set `err`;
  - flush the FIFO (pointers, count, `last_cnt` to 0);
  - go to IDLE.
  
  `err` stays set until `reset`.
- No arithmetic; data passes through unmodified. Pointer width is `$clog2(DEPTH)`; count width is `$clog2(DEPTH)+1`. Pointers wrap modulo DEPTH.

## Timing
- Reset (sync): state IDLE, FIFO empty, `last_cnt=0`, `skew=0`, `valid=0`, `a_in1=a_in2=0`, `done=0`, `err=0`, `busy=0`, `in_ready=1`. Reset mid-stream aborts the matrix and discards all FIFO contents.
- Latency: a push of the last vector at edge t gives `last_cnt≥1` after t. STREAM is entered at t+1. The first `valid` output is visible after edge t+2.
- An N-row matrix yields exactly N+1 consecutive `valid` cycles:
  - cycle k (0..N-1): `a_in1=A[k][0]`, `a_in2=A[k-1][1]`, with `A[-1]=0`;
  - cycle N: `a_in1=0`, `a_in2=A[N-1][1]`, `done=1`.
- At least one IDLE cycle (`valid=0`) separates matrices.
- Push and pop in the same cycle when full: `in_ready` is based on registered full, so the push is refused that cycle.
- `in_ready` deasserts the cycle after the count reaches DEPTH.

## Structure
- `tpu_pkg`: `DATA_W` default, the `act_vec_t` packed struct {a0, a1, last}, and the `feeder_state_t` enum {IDLE, STREAM, DRAIN}.
- Sub-module `sync_fifo`, parameterised on width and depth. It provides push/pop, full/empty and a flush input. It is reusable for the unified-buffer read path.
- FSM, `last_cnt`, skew register and output registers live in `input_skew_feeder`.

## Test plan
- Reset, then push rows (1,2), (3,4 last). Required outputs:
  - valid cycle 1: (1,0)
  - valid cycle 2: (3,2)
  - valid cycle 3: (0,4) with `done`
  - then `valid=0`.
- Single row (5,6 last) gives (5,0), then (0,6) with `done`. This covers the N=1 boundary.
- Push matrix X = (1,1), (2,2 last) and, while it streams, matrix Y = (7,8 last). X outputs complete, one idle cycle follows, then Y outputs (7,0), (0,8). `last_cnt` stays correct under simultaneous push/pop.
- Push 8 rows with no `last` (DEPTH=8). Required response:
  - `in_ready` drops;
  - `err=1` is sticky;
  - FIFO flushes;
  - no `valid` is ever asserted;
  - after `reset`, `err=0` and normal traffic works.
- Assert `reset` in the 2nd STREAM cycle of a 4-row matrix. The next cycle has all outputs 0, IDLE, and the FIFO empty. The leftover rows are never emitted.
- Fill to DEPTH with `last` on row 8, holding `in_valid`. `in_ready=0` is seen while full, and wrap-around pointer order is preserved across two consecutive 8-row matrices.
